cpu_core: RTL and testbench



---
 rtl/cpu_core_pkg.sv | 82 ++++++++
 rtl/cpu_core_alu.sv | 108 ++++++++++
 rtl/cpu_core.sv | 124 ++++++++++++
 tb/tb_cpu_core.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/cpu_core_pkg.sv
`default_nettype none
// cpu_core_pkg: shared encodings, condition codes, FSM states and flag indices (rev 1.0)
package cpu_core_pkg;

  localparam int FLAG_W = 5;
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_F = 2;
  localparam int FLAG_L = 3;
  localparam int FLAG_N = 4;

  localparam logic [3:0] OP_REG   = 4'b0000;
  localparam logic [3:0] OP_SHIFT = 4'b1000;
  localparam logic [3:0] OP_MEM   = 4'b0100;
  localparam logic [3:0] OP_BCOND = 4'b1100;

  // ALU function codes double as the immediate-form opcodes
  localparam logic [3:0] FN_ADD = 4'b0101;
  localparam logic [3:0] FN_SUB = 4'b1001;
  localparam logic [3:0] FN_CMP = 4'b1011;
  localparam logic [3:0] FN_AND = 4'b0001;
  localparam logic [3:0] FN_OR  = 4'b0010;
  localparam logic [3:0] FN_XOR = 4'b0011;
  localparam logic [3:0] FN_MOV = 4'b1101;
  localparam logic [3:0] FN_LUI = 4'b1111;

  localparam logic [3:0] EXT_LSH   = 4'b0100;
  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STOR  = 4'b0100;
  localparam logic [3:0] EXT_JCOND = 4'b1000;
  localparam logic [3:0] EXT_JAL   = 4'b1100;

  localparam logic [3:0] CC_EQ = 4'b0000;
  localparam logic [3:0] CC_NE = 4'b0001;
  localparam logic [3:0] CC_CS = 4'b0010;
  localparam logic [3:0] CC_CC = 4'b0011;
  localparam logic [3:0] CC_HI = 4'b0100;
  localparam logic [3:0] CC_LS = 4'b0101;
  localparam logic [3:0] CC_GT = 4'b0110;
  localparam logic [3:0] CC_LE = 4'b0111;
  localparam logic [3:0] CC_FS = 4'b1000;
  localparam logic [3:0] CC_FC = 4'b1001;
  localparam logic [3:0] CC_LO = 4'b1010;
  localparam logic [3:0] CC_HS = 4'b1011;
  localparam logic [3:0] CC_LT = 4'b1100;
  localparam logic [3:0] CC_GE = 4'b1101;
  localparam logic [3:0] CC_UC = 4'b1110;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4
  } state_t;

  function automatic logic cond_true(input logic [3:0] cond, input logic [FLAG_W-1:0] f);
    logic taken;
    taken = 1'b0;
    case (cond)
      CC_EQ:   taken = f[FLAG_Z];
      CC_NE:   taken = !f[FLAG_Z];
      CC_CS:   taken = f[FLAG_C];
      CC_CC:   taken = !f[FLAG_C];
      CC_HI:   taken = !f[FLAG_L] && !f[FLAG_Z];
      CC_LS:   taken = f[FLAG_L] || f[FLAG_Z];
      CC_GT:   taken = !f[FLAG_N] && !f[FLAG_Z];
      CC_LE:   taken = f[FLAG_N] || f[FLAG_Z];
      CC_FS:   taken = f[FLAG_F];
      CC_FC:   taken = !f[FLAG_F];
      CC_LO:   taken = f[FLAG_L];
      CC_HS:   taken = !f[FLAG_L];
      CC_LT:   taken = f[FLAG_N];
      CC_GE:   taken = !f[FLAG_N];
      CC_UC:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_core_alu.sv
`default_nettype none
// cpu_alu: combinational ALU and shifter producing the rd result and next flags (rev 1.0)
module cpu_alu
  import cpu_core_pkg::*;
(
  input  logic [3:0]        op,
  input  logic [3:0]        ext,
  input  logic [7:0]        imm8,
  input  logic [15:0]       a,
  input  logic [15:0]       b,
  input  logic [FLAG_W-1:0] flags_in,
  output logic [15:0]       result,
  output logic              reg_we,
  output logic [FLAG_W-1:0] flags_out
);

  logic [3:0]  fn;
  logic [15:0] src;
  logic [16:0] sum;
  logic [16:0] diff;
  logic [4:0]  mag;
  logic        left;
  logic [15:0] shifted;

  always_comb begin
    fn  = op;
    src = {8'h00, imm8};
    if (op == OP_REG) begin
      fn  = ext;
      src = b;
    end else if (op == FN_ADD || op == FN_SUB || op == FN_CMP) begin
      src = {{8{imm8[7]}}, imm8};
    end
  end

  assign sum  = {1'b0, a} + {1'b0, src};
  assign diff = {1'b0, a} - {1'b0, src};

  // LSH takes a signed 5-bit count from rs; negative counts shift right
  always_comb begin
    left = !ext[0];
    mag  = {1'b0, imm8[3:0]};
    if (ext == EXT_LSH) begin
      left = !b[4];
      mag  = b[4] ? (5'd0 - b[4:0]) : b[4:0];
    end
  end

  assign shifted = left ? (a << mag) : (a >> mag);

  always_comb begin
    result    = a;
    reg_we    = 1'b0;
    flags_out = flags_in;
    if (op == OP_SHIFT) begin
      if (ext == EXT_LSH || ext[3:1] == 3'b000) begin
        result = shifted;
        reg_we = 1'b1;
      end
    end else begin
      // memory, branch and undefined opcodes match no function code
      case (fn)
        FN_ADD: begin
          result            = sum[15:0];
          reg_we            = 1'b1;
          flags_out[FLAG_C] = sum[16];
          flags_out[FLAG_F] = (a[15] == src[15]) && (sum[15] != a[15]);
        end
        FN_SUB: begin
          result            = diff[15:0];
          reg_we            = 1'b1;
          flags_out[FLAG_C] = diff[16];
          flags_out[FLAG_F] = (a[15] != src[15]) && (diff[15] != a[15]);
        end
        FN_CMP: begin
          flags_out[FLAG_Z] = (a == src);
          flags_out[FLAG_L] = (a < src);
          flags_out[FLAG_N] = ($signed(a) < $signed(src));
        end
        FN_AND: begin
          result = a & src;
          reg_we = 1'b1;
        end
        FN_OR: begin
          result = a | src;
          reg_we = 1'b1;
        end
        FN_XOR: begin
          result = a ^ src;
          reg_we = 1'b1;
        end
        FN_MOV: begin
          result = src;
          reg_we = 1'b1;
        end
        FN_LUI: begin
          if (op == FN_LUI) begin
            result = {imm8, a[7:0]};
            reg_we = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/cpu_core.sv
`default_nettype none
// cpu_core: multi-cycle 16-bit load/store core on a shared 1-cycle-latency RAM (rev 1.0)
module cpu_core
  import cpu_core_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] data_read_data,
  output logic        data_write_enable,
  output logic [15:0] data_address,
  output logic [15:0] data_write_data
);

  state_t            state;
  state_t            next_state;
  logic [15:0]       pc;
  logic [15:0]       ir;
  logic [15:0][15:0] regs;
  logic [FLAG_W-1:0] flags;

  logic [3:0]  op;
  logic [3:0]  rd_idx;
  logic [3:0]  ext;
  logic [3:0]  rs_idx;
  logic [7:0]  imm8;
  logic [15:0] rd_val;
  logic [15:0] rs_val;
  logic        is_load;
  logic        is_store;
  logic        is_jal;
  logic        taken;
  logic [15:0] pc_inc;
  logic [15:0] exec_pc;

  logic [15:0]       alu_result;
  logic              alu_reg_we;
  logic [FLAG_W-1:0] alu_flags;

  assign op       = ir[15:12];
  assign rd_idx   = ir[11:8];
  assign ext      = ir[7:4];
  assign rs_idx   = ir[3:0];
  assign imm8     = ir[7:0];
  assign rd_val   = regs[rd_idx];
  assign rs_val   = regs[rs_idx];
  assign is_load  = (op == OP_MEM) && (ext == EXT_LOAD);
  assign is_store = (op == OP_MEM) && (ext == EXT_STOR);
  assign is_jal   = (op == OP_MEM) && (ext == EXT_JAL);
  assign taken    = cond_true(rd_idx, flags);
  assign pc_inc   = pc + 16'd1;

  cpu_alu u_alu (
    .op        (op),
    .ext       (ext),
    .imm8      (imm8),
    .a         (rd_val),
    .b         (rs_val),
    .flags_in  (flags),
    .result    (alu_result),
    .reg_we    (alu_reg_we),
    .flags_out (alu_flags)
  );

  always_comb begin
    exec_pc = pc_inc;
    if (op == OP_BCOND) begin
      if (taken) exec_pc = pc + {{8{imm8[7]}}, imm8};
    end else if (op == OP_MEM) begin
      if (is_jal || (ext == EXT_JCOND && taken)) exec_pc = rs_val;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= next_state;
  end

  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:   next_state = S_DECODE;
      S_DECODE:  next_state = S_EXECUTE;
      S_EXECUTE: next_state = (is_load || is_store) ? S_MEM : S_FETCH;
      S_MEM:     next_state = is_load ? S_WB : S_FETCH;
      S_WB:      next_state = S_FETCH;
      default:   next_state = S_FETCH;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc    <= '0;
      ir    <= '0;
      regs  <= '0;
      flags <= '0;
    end else begin
      case (state)
        S_DECODE: ir <= data_read_data;
        S_EXECUTE: begin
          if (!is_load && !is_store) begin
            pc    <= exec_pc;
            flags <= alu_flags;
            if (alu_reg_we) regs[rd_idx] <= alu_result;
            if (is_jal)     regs[rd_idx] <= pc_inc;
          end
        end
        S_MEM: begin
          if (is_store) pc <= pc_inc;
        end
        S_WB: begin
          regs[rd_idx] <= data_read_data;
          pc           <= pc_inc;
        end
        default: ;
      endcase
    end
  end

  assign data_address      = (state == S_MEM) ? rs_val : pc;
  assign data_write_enable = (state == S_MEM) && is_store;
  assign data_write_data   = rd_val;

endmodule
`default_nettype wire

// File: tb/tb_cpu_core.sv
`default_nettype none
// tb_cpu_core: directed program run against cpu_core with a behavioural 1-cycle RAM (rev 1.0)
module tb_cpu_core;
  import cpu_core_pkg::*;

  logic        clock = 1'b1;
  logic        reset = 1'b0;
  logic [15:0] data_read_data = 16'h0000;
  logic        data_write_enable;
  logic [15:0] data_address;
  logic [15:0] data_write_data;

  logic [15:0] mem [0:65535];
  logic [15:0] exp_fetch [0:29];
  logic [15:0] exp_regs [0:15];

  int errors = 0;
  int checks = 0;
  int cycle  = 0;
  logic [15:0] fetch_addr [$];
  int          fetch_cyc [$];
  int          store_count = 0;
  logic [15:0] store_addr = 16'h0000;
  logic [15:0] store_data = 16'h0000;

  cpu_core dut (
    .clock             (clock),
    .reset             (reset),
    .data_read_data    (data_read_data),
    .data_write_enable (data_write_enable),
    .data_address      (data_address),
    .data_write_data   (data_write_data)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (data_write_enable) mem[data_address] <= data_write_data;
    data_read_data <= mem[data_address];
  end

  always @(negedge clock) begin
    if (reset) begin
      if (dut.state == S_FETCH) begin
        fetch_addr.push_back(data_address);
        fetch_cyc.push_back(cycle);
      end
      if (data_write_enable) begin
        store_count = store_count + 1;
        store_addr  = data_address;
        store_data  = data_write_data;
      end
      cycle = cycle + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[0]  = 16'hD105;  // MOVI r1,0x05
    mem[1]  = 16'h51FF;  // ADDI r1,-1
    mem[2]  = 16'hC202;  // BCS +2
    mem[3]  = 16'hD8EE;
    mem[4]  = 16'hD27F;  // MOVI r2,0x7F
    mem[5]  = 16'hF27F;  // LUI r2,0x7F
    mem[6]  = 16'h5201;  // ADDI r2,1
    mem[7]  = 16'hC802;  // BFS +2
    mem[8]  = 16'hD901;
    mem[9]  = 16'hD310;  // MOVI r3,0x10
    mem[10] = 16'hD4AB;  // MOVI r4,0xAB
    mem[11] = 16'h4443;  // STOR r4,[r3]
    mem[12] = 16'h4503;  // LOAD r5,[r3]
    mem[13] = 16'hB104;  // CMPI r1,4
    mem[14] = 16'hC003;  // BEQ +3
    mem[15] = 16'hDAEE;
    mem[16] = 16'hDAEE;
    mem[17] = 16'hC102;  // BNE +2
    mem[18] = 16'hDB22;
    mem[19] = 16'hD720;  // MOVI r7,0x20
    mem[20] = 16'h46C7;  // JAL r6,r7
    mem[21] = 16'hDCF1;  // MOVI r12,0xF1
    mem[22] = 16'h8C04;  // LSHI r12 left 4
    mem[23] = 16'h0DDC;  // MOV r13,r12
    mem[24] = 16'hDEFC;  // MOVI r14,0xFC (-4 in rs[4:0])
    mem[25] = 16'h8C4E;  // LSH r12,r14
    mem[26] = 16'h6DFF;  // undefined opcode
    mem[27] = 16'h0D7C;  // undefined register-ALU ext
    mem[28] = 16'hDF5A;
    mem[29] = 16'hCE00;  // BUC 0 (park)
    mem[32] = 16'hD033;  // MOVI r0,0x33
    mem[33] = 16'h4E86;  // J UC r6

    exp_fetch = '{16'd0, 16'd1, 16'd2, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9, 16'd10,
                  16'd11, 16'd12, 16'd13, 16'd14, 16'd17, 16'd18, 16'd19, 16'd20, 16'd32, 16'd33,
                  16'd21, 16'd22, 16'd23, 16'd24, 16'd25, 16'd26, 16'd27, 16'd28, 16'd29, 16'd29};
    exp_regs = '{16'h0033, 16'h0004, 16'h7F80, 16'h0010, 16'h00AB, 16'h00AB, 16'h0015, 16'h0020,
                 16'h0000, 16'h0001, 16'h0000, 16'h0022, 16'h00F1, 16'h0F10, 16'h00FC, 16'h005A};

    #3;
    check_eq("rst_addr", data_address, 16'h0000);
    check_eq("rst_we", data_write_enable, 1'b0);
    check_eq("rst_wdata", data_write_data, 16'h0000);
    #10;
    check_eq("rst_addr_late", data_address, 16'h0000);
    #9 reset = 1'b1;

    @(negedge clock);
    check_eq("first_fetch_addr", data_address, 16'h0000);
    @(negedge clock);
    @(negedge clock);
    check_eq("first_ir", dut.ir, 16'hD105);

    for (int n = 0; n < 400 && fetch_addr.size() < 30; n++) @(negedge clock);
    check_eq("fetch_count_reached", (fetch_addr.size() >= 30), 1'b1);

    for (int i = 0; i < 30 && i < fetch_addr.size(); i++)
      check_eq($sformatf("fetch_%0d", i), fetch_addr[i], exp_fetch[i]);
    if (fetch_cyc.size() > 28) begin
      check_eq("cyc_load_fetch", fetch_cyc[11], 34);
      check_eq("cyc_after_load", fetch_cyc[12], 39);
      check_eq("cyc_park_fetch", fetch_cyc[28], 87);
    end

    for (int i = 0; i < 16; i++)
      check_eq($sformatf("r%0d", i), dut.regs[i], exp_regs[i]);
    check_eq("flags", dut.flags, 5'b00001);
    check_eq("pc_parked", dut.pc, 16'd29);
    check_eq("store_count", store_count, 1);
    check_eq("store_addr", store_addr, 16'h0010);
    check_eq("store_data", store_data, 16'h00AB);
    check_eq("mem_0x10", mem[16], 16'h00AB);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
